// File: rtl/life_pkg.sv
// Shared types and grid geometry for the Life pattern loader.
package life_pkg;

    localparam int NUM_ROWS = 8;
    localparam int ROW_W    = 3;
    localparam int CELL_W   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } life_state_t;

endpackage

// File: rtl/life_step_timer.sv
// Generation-period prescaler: counts 0..step_div while run is high and ticks at the top.
module life_step_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] step_div,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;

    // >= rather than == so a step_div lowered below the running count fires at once.
    assign tick = run && !clr && (count_reg >= step_div);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (run) begin
            count_next = tick ? '0 : count_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/life_pattern_loader.sv
// Loads an 8x8 Life pattern row by row into the grid and paces generation steps when idle.
// Optional macro LIFE_GEN_COUNTER_EN adds a 16-bit gen_count output counting generation pulses.
module life_pattern_loader
    import life_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [CELL_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              run,
    input  logic [DIV_W-1:0]  step_div,
    output logic [ROW_W-1:0]  row_select,
    output logic [CELL_W-1:0] set_cells,
    output logic [CELL_W-1:0] clear_cells,
    output logic              grid_enable,
    output logic              busy
`ifdef LIFE_GEN_COUNTER_EN
    ,
    output logic [15:0]       gen_count
`endif
);

    life_state_t       state_reg, state_next;
    logic [ROW_W-1:0]  row_ptr_reg, row_ptr_next;
    logic [ROW_W-1:0]  row_select_reg, row_select_next;
    logic [CELL_W-1:0] set_cells_reg, set_cells_next;
    logic [CELL_W-1:0] clear_cells_reg, clear_cells_next;
    logic              grid_enable_reg, grid_enable_next;
    logic              accept;
    logic              timer_run;
    logic              timer_clr;
    logic              timer_tick;

    assign in_ready    = (state_reg == ST_LOAD);
    assign busy        = (state_reg == ST_LOAD);
    assign accept      = in_valid && in_ready;
    assign row_select  = row_select_reg;
    assign set_cells   = set_cells_reg;
    assign clear_cells = clear_cells_reg;
    assign grid_enable = grid_enable_reg;

    // The prescaler only advances in IDLE without a competing load_start, and sits at 0 throughout a load.
    assign timer_run = run && (state_reg == ST_IDLE) && !load_start;
    assign timer_clr = load_start || (state_reg == ST_LOAD);

    life_step_timer #(
        .DIV_W (DIV_W)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (timer_run),
        .clr      (timer_clr),
        .step_div (step_div),
        .tick     (timer_tick)
    );

    always_comb begin
        state_next   = state_reg;
        row_ptr_next = row_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next   = ST_LOAD;
                    row_ptr_next = '0;
                end
            end
            ST_LOAD: begin
                // A restart discards the partial load; a byte taken on the same cycle lands in row 0.
                if (load_start) begin
                    row_ptr_next = accept ? ROW_W'(1) : '0;
                end else if (accept) begin
                    row_ptr_next = row_ptr_reg + ROW_W'(1);
                    if (row_ptr_reg == ROW_W'(NUM_ROWS - 1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                row_ptr_next = '0;
            end
        endcase
    end

    always_comb begin
        row_select_next  = row_select_reg;
        set_cells_next   = '0;
        clear_cells_next = '0;
        if (accept) begin
            row_select_next  = load_start ? '0 : row_ptr_reg;
            set_cells_next   = in_data;
            clear_cells_next = ~in_data;
        end
        grid_enable_next = timer_tick && (state_reg == ST_IDLE) && !load_start && !accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            row_ptr_reg     <= '0;
            row_select_reg  <= '0;
            set_cells_reg   <= '0;
            clear_cells_reg <= '0;
            grid_enable_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            row_ptr_reg     <= row_ptr_next;
            row_select_reg  <= row_select_next;
            set_cells_reg   <= set_cells_next;
            clear_cells_reg <= clear_cells_next;
            grid_enable_reg <= grid_enable_next;
        end
    end

`ifdef LIFE_GEN_COUNTER_EN
    logic [15:0] gen_count_reg;

    assign gen_count = gen_count_reg;

    always_ff @(posedge clk) begin
        if (reset || load_start) begin
            gen_count_reg <= '0;
        end else if (grid_enable_next) begin
            gen_count_reg <= gen_count_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_life_pattern_loader.sv
// Self-checking bench for life_pattern_loader: directed scenarios plus random traffic against a cycle model.
module tb_life_pattern_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       run;
    logic [7:0] step_div;
    logic [2:0] row_select;
    logic [7:0] set_cells;
    logic [7:0] clear_cells;
    logic       grid_enable;
    logic       busy;
`ifdef LIFE_GEN_COUNTER_EN
    logic [15:0] gen_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_loading;
    int         m_row;
    int         m_count;
    int         m_gen;
    bit         m_ge;
    logic [2:0] m_rs;
    logic [7:0] m_set;
    logic [7:0] m_clr;

    life_pattern_loader #(.DIV_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .run         (run),
        .step_div    (step_div),
        .row_select  (row_select),
        .set_cells   (set_cells),
        .clear_cells (clear_cells),
        .grid_enable (grid_enable),
        .busy        (busy)
`ifdef LIFE_GEN_COUNTER_EN
        ,
        .gen_count   (gen_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare all outputs.
    task automatic step(input bit quiet = 1'b0);
        bit acc;
        @(posedge clk);
        acc  = m_loading && in_valid;
        m_ge = 1'b0;
        if (reset) begin
            m_loading = 1'b0;
            m_row     = 0;
            m_count   = 0;
            m_gen     = 0;
            m_rs      = 3'd0;
            m_set     = 8'd0;
            m_clr     = 8'd0;
        end else begin
            if (acc) begin
                m_rs  = load_start ? 3'd0 : 3'(m_row);
                m_set = in_data;
                m_clr = ~in_data;
                if (!quiet) $display("write row=%0d data=%02h", m_rs, in_data);
            end else begin
                m_set = 8'd0;
                m_clr = 8'd0;
            end
            if (load_start) begin
                m_loading = 1'b1;
                m_row     = acc ? 1 : 0;
                m_count   = 0;
                m_gen     = 0;
            end else if (m_loading) begin
                m_count = 0;
                if (acc) begin
                    if (m_row == 7) m_loading = 1'b0;
                    m_row = (m_row + 1) % 8;
                end
            end else if (run) begin
                if (m_count >= int'(step_div)) begin
                    m_ge    = 1'b1;
                    m_count = 0;
                    m_gen   = (m_gen + 1) & 16'hFFFF;
                end else begin
                    m_count++;
                end
            end
        end
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(m_loading));
        check_eq("busy", 32'(busy), 32'(m_loading));
        check_eq("grid_enable", 32'(grid_enable), 32'(m_ge));
        check_eq("row_select", 32'(row_select), 32'(m_rs));
        check_eq("set_cells", 32'(set_cells), 32'(m_set));
        check_eq("clear_cells", 32'(clear_cells), 32'(m_clr));
`ifdef LIFE_GEN_COUNTER_EN
        check_eq("gen_count", 32'(gen_count), 32'(m_gen));
`endif
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
    endtask

    int ge_seen;
    int wr_seen;

    initial begin
        reset    = 1'b1;
        run      = 1'b0;
        step_div = 8'd0;
        idle_inputs();
        m_loading = 0; m_row = 0; m_count = 0; m_gen = 0;
        m_rs = 0; m_set = 0; m_clr = 0; m_ge = 0;
        step(); step();
        reset = 1'b0;
        step();

        // Full load with the fastest stepping requested: no generation pulse may leak in.
        run = 1'b1; step_div = 8'd0;
        step(); step();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        ge_seen = 0;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            in_data  = 8'(1 << r);
            step();
            ge_seen += int'(grid_enable);
        end
        idle_inputs();
        check_eq("full_load_busy_done", 32'(busy), 32'd0);
        check_eq("full_load_last_row", 32'(row_select), 32'd7);
        check_eq("full_load_last_set", 32'(set_cells), 32'h80);
        check_eq("full_load_no_ge", 32'(ge_seen), 32'd0);
        step(); step(); step();

        // Backpressure: valid toggles, pointer must not skip.
        run = 1'b0;
        load_start = 1'b1; step(); load_start = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'($urandom);
            step();
            if (set_cells != 8'h00 || clear_cells != 8'h00) begin
                check_eq("gap_row_order", 32'(row_select), 32'(wr_seen));
                wr_seen++;
            end
        end
        idle_inputs();
        step();
        check_eq("gap_write_count", 32'(wr_seen), 32'd8);

        // Stepping period.
        run = 1'b1; step_div = 8'd3;
        for (int i = 0; i < 8; i++) step();
        ge_seen = 0;
        for (int i = 0; i < 16; i++) begin step(); ge_seen += int'(grid_enable); end
        check_eq("period4_pulses", 32'(ge_seen), 32'd4);
        step_div = 8'd0;
        step(); step();
        ge_seen = 0;
        for (int i = 0; i < 8; i++) begin step(); ge_seen += int'(grid_enable); end
        check_eq("period1_pulses", 32'(ge_seen), 32'd8);

        // Restart after three rows with run high.
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int r = 0; r < 3; r++) begin in_valid = 1'b1; in_data = 8'($urandom); step(); end
        idle_inputs();
        load_start = 1'b1; step(); load_start = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A; step();
        check_eq("restart_row0", 32'(row_select), 32'd0);
        ge_seen = 0;
        for (int r = 1; r < 8; r++) begin
            in_data = 8'($urandom); step();
            ge_seen += int'(grid_enable);
        end
        idle_inputs();
        check_eq("restart_no_ge", 32'(ge_seen), 32'd0);
        step(); step();

        // Reset after five rows written.
        run = 1'b0;
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int r = 0; r < 5; r++) begin in_valid = 1'b1; in_data = 8'($urandom); step(); end
        idle_inputs();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; step();
        reset = 1'b0; in_valid = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_row_select", 32'(row_select), 32'd0);
        check_eq("rst_set", 32'(set_cells), 32'd0);
        step();
        load_start = 1'b1; step(); load_start = 1'b0;
        in_valid = 1'b1; in_data = 8'hC3; step();
        check_eq("post_rst_row0", 32'(row_select), 32'd0);
        check_eq("post_rst_data", 32'(set_cells), 32'hC3);
        idle_inputs();
        for (int i = 0; i < 10; i++) step(1'b1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            load_start = ($urandom_range(0, 24) == 0);
            in_valid   = $urandom_range(0, 1) == 1;
            in_data    = 8'($urandom);
            run        = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) step_div = 8'($urandom_range(0, 6));
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();

`ifdef LIFE_GEN_COUNTER_EN
        // Drive gen_count to 0xFFFF, then watch it wrap.
        run = 1'b0; step_div = 8'd0;
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int r = 0; r < 8; r++) begin in_valid = 1'b1; in_data = 8'($urandom); step(1'b1); end
        idle_inputs();
        step();
        run = 1'b1;
        for (int i = 0; i < 65535; i++) step(1'b1);
        check_eq("gen_preset", 32'(gen_count), 32'hFFFF);
        step();
        check_eq("gen_wrap0", 32'(gen_count), 32'h0000);
        step();
        check_eq("gen_wrap1", 32'(gen_count), 32'h0001);
        load_start = 1'b1; step(); load_start = 1'b0;
        check_eq("gen_load_clear", 32'(gen_count), 32'h0000);
        for (int r = 0; r < 8; r++) begin in_valid = 1'b1; in_data = 8'($urandom); step(1'b1); end
        idle_inputs();
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_pattern_loader.md
LIFE_PATTERN_LOADER -- requirements
Module: life_pattern_loader

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the generation-period divider.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  pulse; begins loading a full pattern at row 0.
REQ-005 SHALL have port in_data  input  8  row pattern byte, bit i = cell i.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port run  input  1  free-run generation stepping when idle.
REQ-009 SHALL have port step_div  input  DIV_W  generation period minus one, in cycles.
REQ-010 SHALL have ports row_select (output, 3), set_cells (output, 8), clear_cells (output, 8), which drive the grid write port.
REQ-011 SHALL have port grid_enable  output  1  one-cycle generation-advance pulse to the grid.
REQ-012 SHALL have port busy  output  1  high while in LOAD.

Function
REQ-013 SHALL implement FSM states IDLE and LOAD: IDLE->LOAD on load_start; LOAD->IDLE on acceptance of row 7.
REQ-014 SHALL assert in_ready = 1 and busy = 1 in LOAD only.
REQ-015 SHALL accept a byte on any cycle with in_valid && in_ready, writing it to the row held in a 3-bit row pointer, then increment the pointer.
REQ-016 SHALL register write outputs, one cycle after acceptance: row_select = row written, set_cells = in_data, clear_cells = ~in_data.
REQ-017 SHALL drive set_cells = clear_cells = 0 on every cycle without a write; row_select holds its last value.
REQ-018 SHALL restart at row 0 with the partial load discarded (no rollback) when load_start arrives in LOAD; a byte accepted that same cycle is written to row 0.
REQ-019 SHALL, in IDLE with run = 1, count a prescaler 0..step_div and pulse grid_enable for one cycle when count >= step_div, then reset count to 0.
REQ-020 SHALL pulse grid_enable every cycle when step_div = 0, and every 256 cycles when step_div = 255 (DIV_W = 8).
REQ-021 SHALL apply a step_div reduced below the current count on the next cycle (>= compare, no overrun).
REQ-022 SHALL hold the prescaler when run = 0 in IDLE, and clear it on entry to LOAD and on return to IDLE.
REQ-023 SHALL force grid_enable = 0 in LOAD, on the load_start cycle, and on every cycle with a registered write active; load_start outranks run.

Reset
REQ-024 SHALL, on reset, enter IDLE with row pointer 0, prescaler 0, and all outputs 0 (in_ready, busy, grid_enable, row_select, set_cells, clear_cells, gen_count).
REQ-025 SHALL, when reset is asserted mid-load, abandon the load with no further writes issued from the next cycle.

Configuration
REQ-026 SHALL, with macro LIFE_GEN_COUNTER_EN defined, add output gen_count (16 bits): +1 per grid_enable pulse, wraps 0xFFFF->0x0000, cleared on reset and on entry to LOAD.
REQ-027 SHALL, without LIFE_GEN_COUNTER_EN, omit the gen_count port and counter entirely; all other behaviour is identical.

Structure
REQ-028 SHALL place the state enum, NUM_ROWS = 8, ROW_W = 3 and CELL_W = 8 in shared package life_pkg.
REQ-029 SHALL implement the prescaler as sub-module life_step_timer (inputs: clk, reset, run, clr, step_div; output: tick).

Verification
REQ-030 SHALL cover full load: load_start, then bytes 0x01,0x02,..,0x80 with in_valid held -> eight writes, row r has set_cells = 1<<r and clear_cells = ~(1<<r); busy falls after row 7; no grid_enable throughout.
REQ-031 SHALL cover backpressure gaps: in_valid toggling 1,0,1 in LOAD -> writes only on valid cycles, row pointer advances without skipping.
REQ-032 SHALL cover stepping: run = 1, step_div = 3, IDLE -> grid_enable every 4th cycle; step_div = 0 -> every cycle.
REQ-033 SHALL cover restart and priority: load_start after 3 rows, with run = 1 -> next byte goes to row 0, grid_enable stays 0 until row 7 is done.
REQ-034 SHALL cover reset mid-load after row 4 -> busy = 0, all outputs 0 next cycle; the following load starts at row 0.
REQ-035 SHALL cover, with LIFE_GEN_COUNTER_EN, gen_count preset near 0xFFFF, then two pulses -> 0x0000 then 0x0001; load_start -> 0.
